demux1t2_5_buf: RTL and testbench
=================================

Name: demux1t2_5_buf

Overview:
- Inverse of the 5-bit 2-to-1 select path in the datapath.
- Takes one stream of 5-bit words, each tagged with a select bit, and routes every word to output port 0 or port 1.
- Each output port has its own small FIFO and a valid/ready handshake.
- Used wherever a single producer (e.g. register-address source) must feed two independent consumers that stall independently.

Parameters:
- W, 5, data width in bits.
- DEPTH, 2, entries per output FIFO; power of two, >= 2.
- CW, 8, width of per-port delivered-word counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- I  input  W  input data word.
- s  input  1  route select; 0 -> port 0, 1 -> port 1; qualified by in_valid.
- in_valid  input  1  I/s valid.
- in_ready  output  1  block can accept the word addressed by s this cycle.
- o0  output  W  port 0 head-of-FIFO data.
- o0_valid  output  1  port 0 FIFO non-empty.
- o0_ready  input  1  port 0 consumer accepts.
- o1  output  W  port 1 head-of-FIFO data.
- o1_valid  output  1  port 1 FIFO non-empty.
- o1_ready  input  1  port 1 consumer accepts.
- cnt0  output  CW  words delivered on port 0, modulo 2^CW.
- cnt1  output  CW  words delivered on port 1, modulo 2^CW.

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - Both FIFOs empty; read/write pointers and occupancy 0.
  - o0_valid = o1_valid = 0; cnt0 = cnt1 = 0.
  - o0/o1 = 0.
  - Contents in flight are discarded; no words are delivered after release until new input is accepted.
- in_ready = (s ? !full1 : !full0). Combinational from s and registered occupancy only; independent of in_valid and of o*_ready.
- Input accept: in_valid && in_ready at a clk edge writes I into FIFO[s].
- Per-port FIFO behaviour:
  - Latency: a word accepted at edge N appears on oX with oX_valid = 1 after edge N, i.e. one cycle later. No combinational pass-through.
  - oX_valid = (occupancy != 0). oX is always the oldest word; it holds stable while oX_valid && !oX_ready.
  - Pop: oX_valid && oX_ready at an edge advances the read pointer and increments cntX. cntX wraps from 2^CW-1 to 0.
  - oX_ready while oX_valid = 0 is ignored: no pointer or counter change.
  - Simultaneous push and pop on the same port with 0 < occupancy < DEPTH: occupancy unchanged, order preserved.
  - Full port (occupancy = DEPTH): in_ready = 0 for words addressed to it, even if that port pops in the same cycle. No bypass-on-full.
  - Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
- Ordering and isolation:
  - Words for the same port leave in arrival order.
  - No ordering is guaranteed between ports.
  - A full port never blocks words addressed to the other port; in_ready re-evaluates with s each cycle.
- Input rules: I and s may change freely when in_valid = 0. The producer must hold I/s stable while in_valid && !in_ready.
- No X propagation: outputs are driven from registers (o0/o1 from FIFO storage at the read pointer) or from the registered full flags.

Test Plan:
- Reset then idle: rst_n = 0 for 3 cycles, release.
  -> o0_valid = o1_valid = 0, cnt0 = cnt1 = 0, in_ready = 1 for s = 0 and for s = 1.
- Routing and latency: o0_ready = o1_ready = 1; send (I=5'h0A, s=0) then (I=5'h15, s=1) on consecutive cycles.
  -> o0 = 0A valid exactly one cycle after its accept edge; o1 = 15 one cycle after its accept edge; cnt0 = 1, cnt1 = 1.
- Backpressure and isolation: o0_ready = 0; send 5'h01, 5'h02 to port 0.
  -> in_ready drops for s = 0 only.
  Then send 5'h1F to port 1.
  -> accepted and delivered.
  Then raise o0_ready.
  -> port 0 delivers 01 then 02; cnt0 = 2.
- Full with simultaneous pop: port 0 full, o0_ready = 1, in_valid = 1, s = 0 in the same cycle.
  -> in_ready = 0, word not taken that cycle; taken the next cycle; no loss or duplication.
- Counter wrap: deliver 256 words on port 1 with CW = 8.
  -> cnt1 goes 255 -> 0; cnt0 unchanged.
- Reset mid-operation: port 0 holding 2 words, port 1 holding 1 word; pulse rst_n low between clock edges.
  -> o0_valid/o1_valid fall immediately, counters 0, no stale words delivered after release.

Source files
------------

// File: rtl/demux1t2_5_buf.sv
// demux1t2_5_buf
//   Routes a single stream of W-bit words to one of two output ports,
//   selected per word by s. Each output port has its own DEPTH-entry FIFO
//   with a valid/ready handshake, so the two consumers can stall
//   independently of each other.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   I, s, in_valid     input word, route select (0 -> port 0, 1 -> port 1), valid
//   in_ready           the FIFO addressed by s has room this cycle
//   o0, o0_valid       port 0 head-of-FIFO word, FIFO non-empty
//   o0_ready           port 0 consumer accepts
//   o1, o1_valid       port 1 head-of-FIFO word, FIFO non-empty
//   o1_ready           port 1 consumer accepts
//   cnt0, cnt1         words delivered per port, modulo 2^CW

module demux1t2_5_buf #(
    parameter int W     = 5,
    parameter int DEPTH = 2,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  I,
    input  logic          s,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  o0,
    output logic          o0_valid,
    input  logic          o0_ready,
    output logic [W-1:0]  o1,
    output logic          o1_valid,
    input  logic          o1_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    localparam int AW = $clog2(DEPTH);

    // DEPTH is a power of two, so the full occupancy is just the top bit set.
    localparam logic [AW:0] OCC_FULL = {1'b1, {AW{1'b0}}};

    // Per-port state, indexed by port number (0 or 1).
    logic [W-1:0]  r_mem [2][DEPTH];
    logic [AW-1:0] r_wptr [2];
    logic [AW-1:0] r_rptr [2];
    logic [AW:0]   r_occ  [2];
    logic [CW-1:0] r_cnt  [2];

    logic [1:0] w_outReady;
    logic [1:0] w_full;
    logic [1:0] w_push;
    logic [1:0] w_pop;

    // Full flags come only from registered occupancy, so in_ready never
    // depends on o*_ready: a full port refuses input even while it pops.
    always_comb begin
        w_outReady = {o1_ready, o0_ready};
        w_full     = '0;
        w_pop      = '0;
        w_push     = '0;
        for (int p = 0; p < 2; p++) begin
            w_full[p] = (r_occ[p] == OCC_FULL);
            w_pop[p]  = (r_occ[p] != '0) && w_outReady[p];
        end
        w_push[0] = in_valid && !s && !w_full[0];
        w_push[1] = in_valid &&  s && !w_full[1];
    end

    assign in_ready = s ? !w_full[1] : !w_full[0];

    // Storage is cleared on reset so the head-of-FIFO outputs read 0
    // rather than stale or unknown data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    r_mem[p][d] <= '0;
                end
                r_wptr[p] <= '0;
                r_rptr[p] <= '0;
                r_occ[p]  <= '0;
                r_cnt[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_push[p]) begin
                    r_mem[p][r_wptr[p]] <= I;
                    r_wptr[p]           <= r_wptr[p] + 1'b1;
                end
                if (w_pop[p]) begin
                    r_rptr[p] <= r_rptr[p] + 1'b1;
                    r_cnt[p]  <= r_cnt[p] + 1'b1;
                end
                // Simultaneous push and pop leaves occupancy unchanged.
                case ({w_push[p], w_pop[p]})
                    2'b10:   r_occ[p] <= r_occ[p] + 1'b1;
                    2'b01:   r_occ[p] <= r_occ[p] - 1'b1;
                    default: r_occ[p] <= r_occ[p];
                endcase
            end
        end
    end

    assign o0       = r_mem[0][r_rptr[0]];
    assign o1       = r_mem[1][r_rptr[1]];
    assign o0_valid = (r_occ[0] != '0);
    assign o1_valid = (r_occ[1] != '0);
    assign cnt0     = r_cnt[0];
    assign cnt1     = r_cnt[1];

endmodule

// File: tb/tb_demux1t2_5_buf.sv
// Directed testbench for demux1t2_5_buf. Inputs change on the falling
// edge; outputs are observed on the falling edge (or #1 after an input
// change for the combinational in_ready).

module tb_demux1t2_5_buf;

    logic       clk;
    logic       rst_n;
    logic [4:0] I;
    logic       s;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] o0;
    logic       o0_valid;
    logic       o0_ready;
    logic [4:0] o1;
    logic       o1_valid;
    logic       o1_ready;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int testsRun;
    int testsFailed;

    demux1t2_5_buf #(.W(5), .DEPTH(2), .CW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .I        (I),
        .s        (s),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .o0       (o0),
        .o0_valid (o0_valid),
        .o0_ready (o0_ready),
        .o1       (o1),
        .o1_valid (o1_valid),
        .o1_ready (o1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance through one rising edge and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; I = '0; s = 1'b0;
        o0_ready = 1'b0; o1_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        testsRun++; if (o0_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_o0_valid got %b want 0", o0_valid); end
        testsRun++; if (o1_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_o1_valid got %b want 0", o1_valid); end
        testsRun++; if (cnt0 !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_cnt0 got %0d want 0", cnt0); end
        testsRun++; if (cnt1 !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_cnt1 got %0d want 0", cnt1); end
        testsRun++; if (o0 !== 5'h00) begin testsFailed++; $display("[TB] FAIL reset_o0 got %h want 00", o0); end
        testsRun++; if (o1 !== 5'h00) begin testsFailed++; $display("[TB] FAIL reset_o1 got %h want 00", o1); end
        s = 1'b0; #1;
        testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready_s0 got %b want 1", in_ready); end
        s = 1'b1; #1;
        testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready_s1 got %b want 1", in_ready); end
    endtask

    task automatic test_routing();
        @(negedge clk);
        o0_ready = 1'b1; o1_ready = 1'b1;
        I = 5'h0A; s = 1'b0; in_valid = 1'b1;
        #1;
        testsRun++; if (o0_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL route_no_passthrough got %b want 0", o0_valid); end
        step();
        // 0A accepted at the last edge: visible now, not yet popped.
        testsRun++; if (o0_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL route_o0_valid got %b want 1", o0_valid); end
        testsRun++; if (o0 !== 5'h0A) begin testsFailed++; $display("[TB] FAIL route_o0_data got %h want 0a", o0); end
        testsRun++; if (o1_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL route_o1_idle got %b want 0", o1_valid); end
        I = 5'h15; s = 1'b1;
        step();
        testsRun++; if (cnt0 !== 8'd1) begin testsFailed++; $display("[TB] FAIL route_cnt0 got %0d want 1", cnt0); end
        testsRun++; if (o0_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL route_o0_drained got %b want 0", o0_valid); end
        testsRun++; if (o1_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL route_o1_valid got %b want 1", o1_valid); end
        testsRun++; if (o1 !== 5'h15) begin testsFailed++; $display("[TB] FAIL route_o1_data got %h want 15", o1); end
        in_valid = 1'b0;
        step();
        testsRun++; if (cnt1 !== 8'd1) begin testsFailed++; $display("[TB] FAIL route_cnt1 got %0d want 1", cnt1); end
        testsRun++; if (o1_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL route_o1_drained got %b want 0", o1_valid); end
    endtask

    task automatic test_backpressure();
        o0_ready = 1'b0; o1_ready = 1'b1;
        I = 5'h01; s = 1'b0; in_valid = 1'b1;
        #1;
        testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_ready_empty got %b want 1", in_ready); end
        step();
        I = 5'h02;
        step();
        // Port 0 now holds 01, 02 and is full.
        s = 1'b0; #1;
        testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_ready_s0_full got %b want 0", in_ready); end
        I = 5'h1F; s = 1'b1; #1;
        testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_ready_s1_free got %b want 1", in_ready); end
        testsRun++; if (o0 !== 5'h01) begin testsFailed++; $display("[TB] FAIL bp_o0_head got %h want 01", o0); end
        step();
        testsRun++; if (o1_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_o1_valid got %b want 1", o1_valid); end
        testsRun++; if (o1 !== 5'h1F) begin testsFailed++; $display("[TB] FAIL bp_o1_data got %h want 1f", o1); end
        in_valid = 1'b0;
        step();
        testsRun++; if (cnt1 !== 8'd2) begin testsFailed++; $display("[TB] FAIL bp_cnt1 got %0d want 2", cnt1); end
        testsRun++; if (o0 !== 5'h01) begin testsFailed++; $display("[TB] FAIL bp_o0_hold got %h want 01", o0); end
        testsRun++; if (cnt0 !== 8'd1) begin testsFailed++; $display("[TB] FAIL bp_cnt0_stalled got %0d want 1", cnt0); end
        o0_ready = 1'b1;
        step();
        testsRun++; if (o0 !== 5'h02) begin testsFailed++; $display("[TB] FAIL bp_o0_second got %h want 02", o0); end
        testsRun++; if (cnt0 !== 8'd2) begin testsFailed++; $display("[TB] FAIL bp_cnt0_one got %0d want 2", cnt0); end
        step();
        testsRun++; if (cnt0 !== 8'd3) begin testsFailed++; $display("[TB] FAIL bp_cnt0_two got %0d want 3", cnt0); end
        testsRun++; if (o0_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_o0_drained got %b want 0", o0_valid); end
    endtask

    task automatic test_full_pop();
        o0_ready = 1'b0;
        I = 5'h03; s = 1'b0; in_valid = 1'b1;
        step();
        I = 5'h04;
        step();
        // Full, and the consumer pops in this same cycle: still no room.
        o0_ready = 1'b1; I = 5'h05; s = 1'b0; in_valid = 1'b1;
        #1;
        testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_pop_ready got %b want 0", in_ready); end
        step();
        testsRun++; if (o0 !== 5'h04) begin testsFailed++; $display("[TB] FAIL full_pop_head got %h want 04", o0); end
        testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_pop_ready_next got %b want 1", in_ready); end
        testsRun++; if (cnt0 !== 8'd4) begin testsFailed++; $display("[TB] FAIL full_pop_cnt0a got %0d want 4", cnt0); end
        step();
        testsRun++; if (o0 !== 5'h05) begin testsFailed++; $display("[TB] FAIL full_pop_taken got %h want 05", o0); end
        testsRun++; if (o0_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_pop_valid got %b want 1", o0_valid); end
        in_valid = 1'b0;
        step();
        testsRun++; if (cnt0 !== 8'd6) begin testsFailed++; $display("[TB] FAIL full_pop_cnt0b got %0d want 6", cnt0); end
        testsRun++; if (o0_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_pop_no_dup got %b want 0", o0_valid); end
    endtask

    task automatic test_wrap();
        logic [7:0] expCnt;
        logic [4:0] expWord;
        int         idx;
        o1_ready = 1'b1; s = 1'b1; in_valid = 1'b1;
        // One word per cycle: after edge i, word i is at the head and
        // i earlier words have left, on top of the 2 already delivered.
        for (int i = 0; i < 256; i++) begin
            idx = i;
            I = idx[4:0];
            step();
            expCnt  = 8'(2 + i);
            expWord = idx[4:0];
            testsRun++; if (cnt1 !== expCnt) begin testsFailed++; $display("[TB] FAIL wrap_cnt1[%0d] got %0d want %0d", i, cnt1, expCnt); end
            testsRun++; if (o1 !== expWord) begin testsFailed++; $display("[TB] FAIL wrap_order[%0d] got %h want %h", i, o1, expWord); end
            if (i == 253) begin
                testsRun++; if (cnt1 !== 8'd255) begin testsFailed++; $display("[TB] FAIL wrap_at_255 got %0d want 255", cnt1); end
            end
            if (i == 254) begin
                testsRun++; if (cnt1 !== 8'd0) begin testsFailed++; $display("[TB] FAIL wrap_to_0 got %0d want 0", cnt1); end
            end
        end
        in_valid = 1'b0;
        step();
        testsRun++; if (cnt1 !== 8'd2) begin testsFailed++; $display("[TB] FAIL wrap_final got %0d want 2", cnt1); end
        testsRun++; if (cnt0 !== 8'd6) begin testsFailed++; $display("[TB] FAIL wrap_cnt0_still got %0d want 6", cnt0); end
    endtask

    task automatic test_reset_mid();
        o0_ready = 1'b0; o1_ready = 1'b0;
        I = 5'h11; s = 1'b0; in_valid = 1'b1;
        step();
        I = 5'h12;
        step();
        I = 5'h13; s = 1'b1;
        step();
        in_valid = 1'b0;
        testsRun++; if (o0_valid !== 1'b1 || o1_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_loaded got %b%b want 11", o0_valid, o1_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++; if (o0_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_o0_valid got %b want 0", o0_valid); end
        testsRun++; if (o1_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_o1_valid got %b want 0", o1_valid); end
        testsRun++; if (cnt0 !== 8'd0) begin testsFailed++; $display("[TB] FAIL midrst_cnt0 got %0d want 0", cnt0); end
        testsRun++; if (cnt1 !== 8'd0) begin testsFailed++; $display("[TB] FAIL midrst_cnt1 got %0d want 0", cnt1); end
        testsRun++; if (o0 !== 5'h00) begin testsFailed++; $display("[TB] FAIL midrst_o0 got %h want 00", o0); end
        @(negedge clk);
        rst_n = 1'b1;
        o0_ready = 1'b1; o1_ready = 1'b1;
        repeat (3) step();
        testsRun++; if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_no_stale got %b%b want 00", o0_valid, o1_valid); end
        testsRun++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin testsFailed++; $display("[TB] FAIL midrst_cnt_hold got %0d/%0d want 0/0", cnt0, cnt1); end
        s = 1'b0; #1;
        testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_in_ready got %b want 1", in_ready); end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_routing();
        test_backpressure();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
